// File: rtl/iob_dma_sched.sv
// iob_dma_sched: round-robin scheduler sharing one iob_dma engine between N_REQ
// requesters; programs the DMA config port and reports completion or timeout.
//
// state | meaning
// IDLE  | no descriptor in flight; grant searches cyclically from ptr+1
// CFG   | dma_cfg_valid_o held high with a stable descriptor until accepted
// WAIT  | transfer running; watchdog down-counter armed
// DONE  | one-cycle done pulse (err = timed out) to the granted requester
module iob_dma_sched #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 32,
    parameter int TIMEOUT_W = 16,
    localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    output logic [N_REQ-1:0]        req_ready_o,
    input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]  req_len_i,
    input  logic [N_REQ-1:0]        req_dir_i,
    output logic [N_REQ-1:0]        done_valid_o,
    output logic                    done_err_o,
    output logic                    dma_cfg_valid_o,
    input  logic                    dma_cfg_ready_i,
    output logic [ADDR_W-1:0]       dma_addr_o,
    output logic [LEN_W-1:0]        dma_len_o,
    output logic                    dma_dir_o,
    output logic [IDX_W-1:0]        dma_if_o,
    input  logic                    dma_done_i,
    output logic                    dma_abort_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Loaded on config accept; reaching zero marks the (2**TIMEOUT_W-2)th WAIT cycle.
    localparam logic [TIMEOUT_W-1:0] WD_LOAD = {{(TIMEOUT_W-2){1'b1}}, 2'b01};

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     if_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_W-1:0]     len_q;
    logic                 dir_q;
    logic                 cfg_valid_q;
    logic [N_REQ-1:0]     done_q;
    logic                 err_q;
    logic [TIMEOUT_W-1:0] wd_q;

    logic                 grant_found;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LEN_W-1:0]     sel_len;
    logic                 sel_dir;
    logic                 run;
    logic                 timeout;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_dir  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
                sel_len  = req_len_i[k*LEN_W +: LEN_W];
                sel_dir  = req_dir_i[k];
            end
        end
    end

    // Combinational pulses only fire on enabled, non-reset cycles so they are seen once.
    assign run     = cke_i && !rst_i && !arst_i;
    assign timeout = (state_q == WAIT) && (wd_q == '0) && !dma_done_i;

    assign req_ready_o     = (run && state_q == IDLE && grant_found) ? onehot(grant_idx) : '0;
    assign dma_abort_o     = run && timeout;
    assign done_valid_o    = done_q;
    assign done_err_o      = err_q;
    assign dma_cfg_valid_o = cfg_valid_q;
    assign dma_addr_o      = addr_q;
    assign dma_len_o       = len_q;
    assign dma_dir_o       = dir_q;
    assign dma_if_o        = if_q;
    assign busy_o          = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(N_REQ - 1);
            if_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            dir_q       <= 1'b0;
            cfg_valid_q <= 1'b0;
            done_q      <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(N_REQ - 1);
            if_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            dir_q       <= 1'b0;
            cfg_valid_q <= 1'b0;
            done_q      <= '0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else if (cke_i) begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        addr_q <= sel_addr;
                        len_q  <= sel_len;
                        dir_q  <= sel_dir;
                        if_q   <= grant_idx;
                        if (sel_len == '0) begin
                            state_q <= DONE;
                            done_q  <= onehot(grant_idx);
                            err_q   <= 1'b0;
                        end else begin
                            state_q     <= CFG;
                            cfg_valid_q <= 1'b1;
                        end
                    end
                end
                CFG: begin
                    if (dma_cfg_ready_i) begin
                        state_q     <= WAIT;
                        cfg_valid_q <= 1'b0;
                        wd_q        <= WD_LOAD;
                    end
                end
                WAIT: begin
                    if (dma_done_i) begin
                        state_q <= DONE;
                        done_q  <= onehot(if_q);
                        err_q   <= 1'b0;
                    end else if (wd_q == '0) begin
                        state_q <= DONE;
                        done_q  <= onehot(if_q);
                        err_q   <= 1'b1;
                    end else begin
                        wd_q <= wd_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= if_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_dma_sched.sv
// Directed bench for iob_dma_sched: single grant, round-robin order, watchdog
// timeout, zero-length descriptor, stalled config, async reset and clock enable.
module tb_iob_dma_sched;

    logic         clk_i = 1'b0;
    logic         arst_i = 1'b1;
    logic         cke_i = 1'b1;
    logic         rst_i = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_addr = '0;
    logic [127:0] req_len = '0;
    logic [3:0]   req_dir = '0;
    logic [3:0]   done_valid;
    logic         done_err;
    logic         cfg_valid;
    logic         cfg_ready = 1'b0;
    logic [31:0]  dma_addr;
    logic [31:0]  dma_len;
    logic         dma_dir;
    logic [1:0]   dma_if;
    logic         dma_done = 1'b0;
    logic         dma_abort;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    iob_dma_sched #(
        .N_REQ(4), .ADDR_W(32), .LEN_W(32), .TIMEOUT_W(4)
    ) dut (
        .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i), .rst_i(rst_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_dir_i(req_dir),
        .done_valid_o(done_valid), .done_err_o(done_err),
        .dma_cfg_valid_o(cfg_valid), .dma_cfg_ready_i(cfg_ready),
        .dma_addr_o(dma_addr), .dma_len_o(dma_len), .dma_dir_o(dma_dir),
        .dma_if_o(dma_if), .dma_done_i(dma_done), .dma_abort_o(dma_abort),
        .busy_o(busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] l, input logic d);
        req_addr[k*32 +: 32] = a;
        req_len[k*32 +: 32]  = l;
        req_dir[k]           = d;
        req_valid[k]         = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (2) tick;
        arst_i = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_done", {done_valid, done_err}, 0);
        chk("rst_abort", dma_abort, 0);
        chk("rst_dma_out", {dma_addr, dma_len, dma_dir, dma_if}, 0);
        chk("rst_ready", req_ready, 0);

        // single request from requester 2
        set_req(2, 32'h1000, 32'd8, 1'b1);
        #1;
        chk("t1_ready", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        #1;
        chk("t1_cfg_valid", cfg_valid, 1);
        chk("t1_addr", dma_addr, 32'h1000);
        chk("t1_len", dma_len, 8);
        chk("t1_dir_if", {dma_dir, dma_if}, {1'b1, 2'd2});
        chk("t1_busy", busy, 1);
        cfg_ready = 1'b1;
        tick;
        cfg_ready = 1'b0;
        #1;
        chk("t1_cfg_drop", cfg_valid, 0);
        repeat (9) tick;
        dma_done = 1'b1;
        #1;
        chk("t1_done_early", done_valid, 0);
        tick;
        dma_done = 1'b0;
        #1;
        chk("t1_done", {done_valid, done_err}, {4'b0100, 1'b0});
        chk("t1_no_abort", dma_abort, 0);
        tick;
        #1;
        chk("t1_idle", {busy, done_valid}, 0);
        chk("t1_hold_addr", {dma_addr, dma_if}, {32'h1000, 2'd2});

        // synchronous reset, then all four requesters valid continuously
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, 32'h100 * (k + 1), k + 1, 1'b0);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_ready", req_ready, 4'b0001 << exp_order[i]);
            tick;
            #1;
            chk("t2_if", dma_if, exp_order[i]);
            chk("t2_addr", dma_addr, 32'h100 * (exp_order[i] + 1));
            chk("t2_ready_cfg", req_ready, 0);
            cfg_ready = 1'b1;
            tick;
            cfg_ready = 1'b0;
            dma_done = 1'b1;
            tick;
            dma_done = 1'b0;
            #1;
            chk("t2_done", {done_valid, done_err}, {4'b0001 << exp_order[i], 1'b0});
            tick;
            #1;
        end

        // watchdog timeout, TIMEOUT_W=4: abort on the 14th WAIT cycle
        req_valid = '0;
        set_req(3, 32'h3000, 32'd4, 1'b0);
        #1;
        chk("t3_ready", req_ready, 4'b1000);
        tick;
        req_valid = '0;
        cfg_ready = 1'b1;
        tick;
        cfg_ready = 1'b0;
        for (int n = 1; n < 14; n++) begin
            #1;
            chk("t3_abort_early", {dma_abort, done_valid}, 0);
            tick;
        end
        #1;
        chk("t3_abort", dma_abort, 1);
        chk("t3_done_early", done_valid, 0);
        tick;
        #1;
        chk("t3_done_err", {done_valid, done_err, dma_abort}, {4'b1000, 1'b1, 1'b0});
        tick;
        #1;
        chk("t3_idle", {busy, done_valid, done_err}, 0);

        // zero-length descriptor from requester 1
        set_req(1, 32'h4000, 32'd0, 1'b1);
        #1;
        chk("t4_ready", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        #1;
        chk("t4_no_cfg", cfg_valid, 0);
        chk("t4_done", {done_valid, done_err}, {4'b0010, 1'b0});
        tick;
        #1;
        chk("t4_idle", {busy, done_valid}, 0);

        // config stalled five cycles, dma_done during CFG ignored
        set_req(0, 32'h5000, 32'd16, 1'b0);
        #1;
        chk("t5_ready", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        dma_done = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("t5_cfg_stable", {cfg_valid, dma_addr, dma_len[15:0], dma_if}, {1'b1, 32'h5000, 16'd16, 2'd0});
            chk("t5_no_done", done_valid, 0);
            tick;
        end
        dma_done = 1'b0;
        cfg_ready = 1'b1;
        #1;
        chk("t5_cfg_still", cfg_valid, 1);
        tick;
        cfg_ready = 1'b0;
        #1;
        chk("t5_wait", {cfg_valid, busy, done_valid}, {1'b0, 1'b1, 4'b0000});

        // async reset during WAIT, then pointer restarts at requester 0
        arst_i = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_outs", {cfg_valid, done_valid, done_err, dma_abort, req_ready}, 0);
        chk("t6_dma_out", {dma_addr, dma_len, dma_dir, dma_if}, 0);
        tick;
        arst_i = 1'b0;
        set_req(2, 32'h6200, 32'd2, 1'b0);
        set_req(0, 32'h6000, 32'd3, 1'b1);
        #1;
        chk("t6_grant0", req_ready, 4'b0001);

        // clock enable low freezes the FSM in CFG
        tick;
        req_valid = '0;
        cke_i = 1'b0;
        cfg_ready = 1'b1;
        tick;
        #1;
        chk("t7_frozen", {cfg_valid, busy}, 2'b11);
        cke_i = 1'b1;
        tick;
        cfg_ready = 1'b0;
        #1;
        chk("t7_wait", {cfg_valid, busy}, 2'b01);
        dma_done = 1'b1;
        tick;
        dma_done = 1'b0;
        #1;
        chk("t7_done", {done_valid, done_err}, {4'b0001, 1'b0});
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

endmodule
